tick_divider_bank: RTL and testbench

- Multi-channel programmable tick generator; generalises the fixed-divisor game-tick counter and the fixed/variable clock dividers into one parametrised bank.
- Each channel divides clk by a run-time-writable divisor. It produces a one-cycle tick pulse and a 50%-duty toggle wave.
- Sits between the processor's memory-mapped I/O write path and the game logic: fall speed, input debounce, display scan and sound.

---
 rtl/tick_pkg.sv | 28 ++
 rtl/tick_divider_bank_if.sv | 35 +++
 rtl/tick_channel.sv | 62 ++++++
 rtl/tick_divider_bank.sv | 91 +++++++++
 tb/tb_tick_divider_bank.sv | 290 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/tick_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------
// tick_pkg : shared constants, types and helpers for the tick bank
// Revision : 1.0
// ---------------------------------------------------------------------
package tick_pkg;

  localparam int unsigned DEFAULT_DIV_GAME = 32'd2500000;
  localparam int unsigned DEFAULT_DIV_SLOW = 32'd10000000;

  localparam int CH_FALL     = 0;
  localparam int CH_DEBOUNCE = 1;
  localparam int CH_SCAN     = 2;
  localparam int CH_SOUND    = 3;

  typedef enum logic [1:0] {
    WR_NONE   = 2'd0,
    WR_LOAD   = 2'd1,
    WR_REJECT = 2'd2
  } wr_result_e;

  // Channel-select width, never narrower than one bit.
  function automatic int ch_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/tick_divider_bank_if.sv
`default_nettype none
// ---------------------------------------------------------------------
// tick_divider_bank_if : divisor write bus of the tick divider bank
// Revision : 1.0
// ---------------------------------------------------------------------
interface tick_divider_bank_if
  import tick_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 32
);

  localparam int CH_W = ch_width(NUM_CH);

  logic             wr_valid;
  logic [CH_W-1:0]  wr_ch;
  logic [CNT_W-1:0] wr_div;
  logic             wr_ready;

  modport master (
    output wr_valid,
    output wr_ch,
    output wr_div,
    input  wr_ready
  );

  modport slave (
    input  wr_valid,
    input  wr_ch,
    input  wr_div,
    output wr_ready
  );

endinterface
`default_nettype wire

// File: rtl/tick_channel.sv
`default_nettype none
// ---------------------------------------------------------------------
// tick_channel : one divisor/counter slice producing tick and wave
// Revision : 1.0
// ---------------------------------------------------------------------
module tick_channel #(
  parameter int               CNT_W       = 32,
  parameter logic [CNT_W-1:0] DEFAULT_DIV = {{(CNT_W-1){1'b0}}, 1'b1}
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             clr,
  input  logic             load,
  input  logic [CNT_W-1:0] load_div,
  output logic             tick,
  output logic             wave
);

  localparam logic [CNT_W-1:0] c_one = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] r_div;
  logic [CNT_W-1:0] r_cnt;
  logic             r_tick;
  logic             r_wave;
  logic [CNT_W-1:0] w_term;

  // Divisor is never zero, so the terminal value cannot underflow.
  assign w_term = r_div - c_one;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_div  <= DEFAULT_DIV;
      r_cnt  <= '0;
      r_tick <= 1'b0;
      r_wave <= 1'b0;
    end else if (load) begin
      r_div  <= load_div;
      r_cnt  <= '0;
      r_tick <= 1'b0;
    end else if (clr) begin
      r_cnt  <= '0;
      r_tick <= 1'b0;
    end else if (en) begin
      if (r_cnt == w_term) begin
        r_cnt  <= '0;
        r_tick <= 1'b1;
        r_wave <= ~r_wave;
      end else begin
        r_cnt  <= r_cnt + c_one;
        r_tick <= 1'b0;
      end
    end else begin
      r_tick <= 1'b0;
    end
  end

  assign tick = r_tick;
  assign wave = r_wave;

endmodule
`default_nettype wire

// File: rtl/tick_divider_bank.sv
`default_nettype none
// ---------------------------------------------------------------------
// tick_divider_bank : multi-channel programmable tick/wave generator
// Revision : 1.0
// ---------------------------------------------------------------------
module tick_divider_bank
  import tick_pkg::*;
#(
  parameter int          NUM_CH      = 4,
  parameter int          CNT_W       = 32,
  parameter int unsigned DEFAULT_DIV = DEFAULT_DIV_GAME
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NUM_CH-1:0] en,
  input  logic              sync,
  input  logic              err_clr,
  tick_divider_bank_if.slave wr,
  output logic [NUM_CH-1:0] tick,
  output logic [NUM_CH-1:0] wave,
  output logic              div_err
);

  localparam int               CH_W          = ch_width(NUM_CH);
  localparam logic [CNT_W-1:0] c_default_div = CNT_W'(DEFAULT_DIV);

  logic       r_ready;
  logic       r_err;
  logic       w_accept;
  logic       w_ch_ok;
  wr_result_e w_result;

  assign w_accept = wr.wr_valid && r_ready;

  // A select field that exactly spans the bank cannot address a missing channel.
  generate
    if ((1 << CH_W) == NUM_CH) begin : g_ch_full
      assign w_ch_ok = 1'b1;
    end else begin : g_ch_part
      assign w_ch_ok = (int'(wr.wr_ch) < NUM_CH);
    end
  endgenerate

  always_comb begin
    w_result = WR_NONE;
    if (w_accept) begin
      w_result = (w_ch_ok && (wr.wr_div != '0)) ? WR_LOAD : WR_REJECT;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ready <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_ready <= 1'b1;
      if (w_result == WR_REJECT) begin
        r_err <= 1'b1;
      end else if (err_clr) begin
        r_err <= 1'b0;
      end
    end
  end

  assign wr.wr_ready = r_ready;
  assign div_err     = r_err;

  generate
    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      logic w_load;

      assign w_load = (w_result == WR_LOAD) && (wr.wr_ch == CH_W'(i));

      tick_channel #(
        .CNT_W       (CNT_W),
        .DEFAULT_DIV (c_default_div)
      ) u_ch (
        .clk      (clk),
        .reset    (reset),
        .en       (en[i]),
        .clr      (sync),
        .load     (w_load),
        .load_div (wr.wr_div),
        .tick     (tick[i]),
        .wave     (wave[i])
      );
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_tick_divider_bank.sv
`default_nettype none
// ---------------------------------------------------------------------
// tb_tick_divider_bank : directed and random checks against a tick model
// Revision : 1.0
// ---------------------------------------------------------------------
module tb_tick_divider_bank;

  localparam int NCH  = 4;
  localparam int CW   = 16;
  localparam int DDIV = 7;

  logic           clk = 1'b0;
  logic           reset;
  logic [NCH-1:0] en;
  logic           sync;
  logic           err_clr;
  logic [NCH-1:0] tick;
  logic [NCH-1:0] wave;
  logic           div_err;

  logic           reset3;
  logic [2:0]     en3;
  logic           sync3;
  logic           err_clr3;
  logic [2:0]     tick3;
  logic [2:0]     wave3;
  logic           err3;

  int total = 0;
  int bad   = 0;

  // Reference model: enabled edges since last clear, tick count since reset.
  int unsigned m_div   [NCH];
  int unsigned m_n     [NCH];
  int unsigned m_ticks [NCH];
  bit          m_tick  [NCH];
  bit          m_err;
  bit          m_ready;

  tick_divider_bank_if #(.NUM_CH(NCH), .CNT_W(CW)) bus ();
  tick_divider_bank_if #(.NUM_CH(3),   .CNT_W(CW)) bus3 ();

  tick_divider_bank #(.NUM_CH(NCH), .CNT_W(CW), .DEFAULT_DIV(DDIV)) dut (
    .clk     (clk),
    .reset   (reset),
    .en      (en),
    .sync    (sync),
    .err_clr (err_clr),
    .wr      (bus),
    .tick    (tick),
    .wave    (wave),
    .div_err (div_err)
  );

  tick_divider_bank #(.NUM_CH(3), .CNT_W(CW), .DEFAULT_DIV(3)) dut3 (
    .clk     (clk),
    .reset   (reset3),
    .en      (en3),
    .sync    (sync3),
    .err_clr (err_clr3),
    .wr      (bus3),
    .tick    (tick3),
    .wave    (wave3),
    .div_err (err3)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NCH; i++) begin
      m_div[i]   = DDIV;
      m_n[i]     = 0;
      m_ticks[i] = 0;
      m_tick[i]  = 1'b0;
    end
    m_err   = 1'b0;
    m_ready = 1'b0;
  endtask

  task automatic model_edge();
    bit acc;
    bit good;
    acc  = bus.wr_valid && m_ready;
    good = acc && (bus.wr_div != 0) && (int'(bus.wr_ch) < NCH);
    for (int i = 0; i < NCH; i++) begin
      if (good && int'(bus.wr_ch) == i) begin
        m_div[i]  = bus.wr_div;
        m_n[i]    = 0;
        m_tick[i] = 1'b0;
      end else if (sync) begin
        m_n[i]    = 0;
        m_tick[i] = 1'b0;
      end else if (en[i]) begin
        m_n[i]    = m_n[i] + 1;
        m_tick[i] = (m_n[i] % m_div[i]) == 0;
        if (m_tick[i]) m_ticks[i] = m_ticks[i] + 1;
      end else begin
        m_tick[i] = 1'b0;
      end
    end
    if (acc && !good) m_err = 1'b1;
    else if (err_clr) m_err = 1'b0;
    m_ready = 1'b1;
  endtask

  task automatic check_all();
    logic [NCH-1:0] et;
    logic [NCH-1:0] ew;
    for (int i = 0; i < NCH; i++) begin
      et[i] = m_tick[i];
      ew[i] = (m_ticks[i] % 2) == 1;
    end
    chk("tick",    32'(tick),         32'(et));
    chk("wave",    32'(wave),         32'(ew));
    chk("div_err", 32'(div_err),      32'(m_err));
    chk("ready",   32'(bus.wr_ready), 32'(m_ready));
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
    model_edge();
    check_all();
  endtask

  initial begin
    reset = 1'b1; en = '0; sync = 1'b0; err_clr = 1'b0;
    bus.wr_valid = 1'b0; bus.wr_ch = '0; bus.wr_div = '0;
    reset3 = 1'b1; en3 = 3'b111; sync3 = 1'b0; err_clr3 = 1'b0;
    bus3.wr_valid = 1'b0; bus3.wr_ch = '0; bus3.wr_div = '0;
    model_reset();

    // Three-channel bank: out-of-range select is rejected, channels undisturbed.
    repeat (2) @(posedge clk);
    #1;
    chk("d3_rst_ready", 32'(bus3.wr_ready), 32'd0);
    reset3 = 1'b0;
    for (int k = 1; k <= 9; k++) begin
      @(posedge clk);
      #1;
      chk("d3_tick", 32'(tick3), (k % 3 == 0) ? 32'd7 : 32'd0);
      chk("d3_err",  32'(err3),  (k >= 2 && k < 5) ? 32'd1 : 32'd0);
      bus3.wr_valid = (k == 1);
      bus3.wr_ch    = 2'd3;
      bus3.wr_div   = 16'd5;
      err_clr3      = (k == 4);
    end

    // Main bank reset state.
    check_all();
    chk("rst_ready", 32'(bus.wr_ready), 32'd0);
    chk("rst_tick",  32'(tick),         32'd0);
    reset = 1'b0;
    cyc();
    chk("ready_up", 32'(bus.wr_ready), 32'd1);

    // ch0 div=5.
    en = 4'b0001;
    bus.wr_valid = 1'b1; bus.wr_ch = 2'd0; bus.wr_div = 16'd5;
    cyc();
    bus.wr_valid = 1'b0;
    for (int k = 1; k <= 15; k++) begin
      cyc();
      chk("c0_tick",  32'(tick[0]),   (k % 5 == 0) ? 32'd1 : 32'd0);
      chk("c0_wave",  32'(wave[0]),   32'((k / 5) % 2));
      chk("c0_other", 32'(tick[3:1]), 32'd0);
    end

    // ch1 div=1: continuous tick, wave toggles every cycle.
    en = 4'b0010;
    bus.wr_valid = 1'b1; bus.wr_ch = 2'd1; bus.wr_div = 16'd1;
    cyc();
    bus.wr_valid = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      cyc();
      chk("c1_tick", 32'(tick[1]), 32'd1);
      chk("c1_wave", 32'(wave[1]), 32'(k % 2));
    end

    // ch2 div=8 paused after three enabled edges.
    en = 4'b0100;
    bus.wr_valid = 1'b1; bus.wr_ch = 2'd2; bus.wr_div = 16'd8;
    cyc();
    bus.wr_valid = 1'b0;
    repeat (3) cyc();
    en = 4'b0000;
    for (int k = 1; k <= 4; k++) begin
      cyc();
      chk("c2_off_tick", 32'(tick[2]), 32'd0);
      chk("c2_off_wave", 32'(wave[2]), 32'd0);
    end
    en = 4'b0100;
    for (int k = 1; k <= 5; k++) begin
      cyc();
      chk("c2_resume", 32'(tick[2]), (k == 8 - 3) ? 32'd1 : 32'd0);
    end
    chk("c2_wave", 32'(wave[2]), 32'd1);

    // Rejected writes and sticky error flag.
    en = 4'b0000;
    bus.wr_valid = 1'b1; bus.wr_ch = 2'd3; bus.wr_div = 16'd0;
    cyc();
    bus.wr_valid = 1'b0;
    chk("err_set", 32'(div_err), 32'd1);
    err_clr = 1'b1;
    cyc();
    chk("err_clr", 32'(div_err), 32'd0);
    bus.wr_valid = 1'b1;
    cyc();
    bus.wr_valid = 1'b0;
    chk("err_set_wins", 32'(div_err), 32'd1);
    cyc();
    err_clr = 1'b0;
    chk("err_clr2", 32'(div_err), 32'd0);

    // Phase alignment with sync.
    bus.wr_valid = 1'b1; bus.wr_ch = 2'd0; bus.wr_div = 16'd4;
    cyc();
    bus.wr_ch = 2'd1; bus.wr_div = 16'd6;
    cyc();
    bus.wr_valid = 1'b0;
    en = 4'b0011;
    repeat (5) cyc();
    sync = 1'b1;
    cyc();
    sync = 1'b0;
    chk("sync_tick", 32'(tick[1:0]), 32'd0);
    for (int k = 1; k <= 12; k++) begin
      cyc();
      chk("sync_t0", 32'(tick[0]), (k % 4 == 0) ? 32'd1 : 32'd0);
      chk("sync_t1", 32'(tick[1]), (k % 6 == 0) ? 32'd1 : 32'd0);
    end
    sync = 1'b1;
    bus.wr_valid = 1'b1; bus.wr_ch = 2'd0; bus.wr_div = 16'd3;
    cyc();
    sync = 1'b0; bus.wr_valid = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      cyc();
      chk("syncwr_t0", 32'(tick[0]), (k % 3 == 0) ? 32'd1 : 32'd0);
      chk("syncwr_t1", 32'(tick[1]), (k % 6 == 0) ? 32'd1 : 32'd0);
    end

    // Asynchronous reset mid-count with wave high.
    en = 4'b0001;
    bus.wr_valid = 1'b1; bus.wr_ch = 2'd0; bus.wr_div = 16'd5;
    cyc();
    bus.wr_valid = 1'b0;
    for (int k = 0; k < 12 && !(m_tick[0] && (m_ticks[0] % 2) == 1); k++) cyc();
    repeat (3) cyc();
    chk("pre_rst_wave", 32'(wave[0]), 32'd1);
    #3;
    reset = 1'b1;
    #1;
    model_reset();
    chk("async_tick",  32'(tick),         32'd0);
    chk("async_wave",  32'(wave),         32'd0);
    chk("async_ready", 32'(bus.wr_ready), 32'd0);
    en = 4'b1111;
    #1;
    reset = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      cyc();
      chk("default_div", 32'(tick), (k == DDIV) ? 32'hf : 32'd0);
    end

    // Random traffic against the model.
    for (int c = 0; c < 400; c++) begin
      en           = 4'($urandom);
      sync         = ($urandom_range(15) == 0);
      err_clr      = ($urandom_range(7) == 0);
      bus.wr_valid = ($urandom_range(3) == 0);
      bus.wr_ch    = 2'($urandom);
      bus.wr_div   = 16'($urandom_range(9));
      cyc();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
